xp_gen_stream: RTL and testbench

//  Parametrised successor to the deskew coordinate generator. Scans a frame of
//  (x_last+1) x (y_last+1) destination pixels, y inner and x outer, and emits per pixel
//  the counters plus two source coordinates, xp and yp, computed incrementally (no

---
 rtl/xp_gen_stream_if.sv | 23 ++
 rtl/xp_gen_stream.sv | 109 ++++++++++
 tb/tb_xp_gen_stream.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xp_gen_stream_if.sv
// Pixel stream of the deskew coordinate generator:
// counters and source coordinates under valid/ready.
interface xp_gen_stream_if #(
   parameter int DIM_W = 9,
   parameter int ACC_W = 24
);
   logic             out_valid;
   logic             out_ready;
   logic [DIM_W-1:0] x_cnt;
   logic [DIM_W-1:0] y_cnt;
   logic [ACC_W-1:0] xp_out;
   logic [ACC_W-1:0] yp_out;

   modport master (
      output out_valid, x_cnt, y_cnt, xp_out, yp_out,
      input  out_ready
   );

   modport slave (
      input  out_valid, x_cnt, y_cnt, xp_out, yp_out,
      output out_ready
   );
endinterface

// File: rtl/xp_gen_stream.sv
// Deskew coordinate generator: scans y inner, x outer,
// and steps xp/yp incrementally with backpressure.
module xp_gen_stream #(
   parameter int DIM_W = 9,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [DIM_W-1:0] x_last,
   input  logic [DIM_W-1:0] y_last,
   input  logic [ACC_W-1:0] off_x,
   input  logic [ACC_W-1:0] off_y,
   input  logic [ACC_W-1:0] inc_xx,
   input  logic [ACC_W-1:0] inc_xy,
   input  logic [ACC_W-1:0] inc_yx,
   input  logic [ACC_W-1:0] inc_yy,
   output logic             busy,
   output logic             done,
   xp_gen_stream_if.master  so
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [DIM_W-1:0] xl_q, yl_q;
   logic [DIM_W-1:0] x_q, y_q;
   logic [ACC_W-1:0] ixx_q, ixy_q, iyx_q, iyy_q;
   logic [ACC_W-1:0] col_x, col_y;
   logic [ACC_W-1:0] xp_q, yp_q;
   logic             accept;
   logic             y_end;
   logic             x_end;
   logic [ACC_W-1:0] col_x_nx;
   logic [ACC_W-1:0] col_y_nx;

   assign accept   = (state == S_RUN) && so.out_ready;
   assign y_end    = (y_q == yl_q);
   assign x_end    = (x_q == xl_q);
   assign col_x_nx = col_x + ixx_q;
   assign col_y_nx = col_y + iyx_q;

   assign busy         = (state == S_RUN);
   assign so.out_valid = (state == S_RUN);
   assign so.x_cnt     = x_q;
   assign so.y_cnt     = y_q;
   assign so.xp_out    = xp_q;
   assign so.yp_out    = yp_q;

   // Frame control, config capture and per-beat coordinate stepping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         done  <= 1'b0;
         xl_q  <= '0;
         yl_q  <= '0;
         x_q   <= '0;
         y_q   <= '0;
         ixx_q <= '0;
         ixy_q <= '0;
         iyx_q <= '0;
         iyy_q <= '0;
         col_x <= '0;
         col_y <= '0;
         xp_q  <= '0;
         yp_q  <= '0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (start && !abort) begin
               state <= S_RUN;
               xl_q  <= x_last;
               yl_q  <= y_last;
               ixx_q <= inc_xx;
               ixy_q <= inc_xy;
               iyx_q <= inc_yx;
               iyy_q <= inc_yy;
               col_x <= off_x;
               col_y <= off_y;
               xp_q  <= off_x;
               yp_q  <= off_y;
               x_q   <= '0;
               y_q   <= '0;
            end
         end else if (abort) begin
            state <= S_IDLE;
            x_q   <= '0;
            y_q   <= '0;
         end else if (accept) begin
            if (!y_end) begin
               y_q  <= y_q + 1'b1;
               xp_q <= xp_q + ixy_q;
               yp_q <= yp_q + iyy_q;
            end else if (!x_end) begin
               y_q   <= '0;
               x_q   <= x_q + 1'b1;
               col_x <= col_x_nx;
               col_y <= col_y_nx;
               xp_q  <= col_x_nx;
               yp_q  <= col_y_nx;
            end else begin
               state <= S_IDLE;
               done  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_xp_gen_stream.sv
// Randomised bench for xp_gen_stream against a
// closed-form model of the frame scan.
module tb_xp_gen_stream;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [8:0]  xl = '0, yl = '0;
   logic [23:0] ox = '0, oy = '0;
   logic [23:0] ixx = '0, ixy = '0, iyx = '0, iyy = '0;
   logic        busy, done;

   xp_gen_stream_if #(.DIM_W(9), .ACC_W(24)) s_if ();

   xp_gen_stream #(.DIM_W(9), .ACC_W(24)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .abort  (abort),
      .x_last (xl),
      .y_last (yl),
      .off_x  (ox),
      .off_y  (oy),
      .inc_xx (ixx),
      .inc_xy (ixy),
      .inc_yx (iyx),
      .inc_yy (iyy),
      .busy   (busy),
      .done   (done),
      .so     (s_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: frame state plus beat index; outputs derived by formula
   logic        m_busy = 1'b0, m_done = 1'b0;
   int          m_idx = 0;
   int          m_mode = 0;
   logic [8:0]  m_xl = '0, m_yl = '0;
   logic [23:0] m_ox = '0, m_oy = '0;
   logic [23:0] m_ixx = '0, m_ixy = '0, m_iyx = '0, m_iyy = '0;

   function automatic int m_n();
      return (int'(m_xl) + 1) * (int'(m_yl) + 1);
   endfunction

   function automatic logic [23:0] f_p(input logic [23:0] o,
      input logic [23:0] ia, input logic [23:0] ib,
      input int x, input int y);
      logic [63:0] t;
      t = 64'(o) + 64'(x) * 64'(ia) + 64'(y) * 64'(ib);
      return t[23:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_idx  <= 0;
         m_mode <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start && !abort) begin
               m_busy <= 1'b1;
               m_idx  <= 0;
               m_mode <= 1;
               m_xl <= xl;   m_yl <= yl;
               m_ox <= ox;   m_oy <= oy;
               m_ixx <= ixx; m_ixy <= ixy;
               m_iyx <= iyx; m_iyy <= iyy;
            end
         end else if (abort) begin
            m_busy <= 1'b0;
            m_mode <= 2;
         end else if (s_if.out_ready) begin
            if (m_idx == m_n() - 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
            end else begin
               m_idx <= m_idx + 1;
            end
         end
      end
   end

   // Per-cycle compare against the model, plus stall stability
   logic        p_stall = 1'b0;
   logic [8:0]  p_x, p_y;
   logic [23:0] p_xp, p_yp;

   always @(negedge clk) begin
      int ex, ey;
      ex = m_idx / (int'(m_yl) + 1);
      ey = m_idx % (int'(m_yl) + 1);
      chk("busy", busy, m_busy);
      chk("valid", s_if.out_valid, m_busy);
      chk("done", done, m_done);
      if (m_mode == 1) begin
         chk("x_cnt", s_if.x_cnt, ex);
         chk("y_cnt", s_if.y_cnt, ey);
         chk("xp", s_if.xp_out, f_p(m_ox, m_ixx, m_ixy, ex, ey));
         chk("yp", s_if.yp_out, f_p(m_oy, m_iyx, m_iyy, ex, ey));
      end else begin
         chk("x_cnt0", s_if.x_cnt, 0);
         chk("y_cnt0", s_if.y_cnt, 0);
         if (m_mode == 0) begin
            chk("xp0", s_if.xp_out, 0);
            chk("yp0", s_if.yp_out, 0);
         end
      end
      if (p_stall && s_if.out_valid) begin
         chk("stall_x", s_if.x_cnt, p_x);
         chk("stall_y", s_if.y_cnt, p_y);
         chk("stall_xp", s_if.xp_out, p_xp);
         chk("stall_yp", s_if.yp_out, p_yp);
      end
      p_stall = s_if.out_valid && !s_if.out_ready;
      p_x  = s_if.x_cnt;
      p_y  = s_if.y_cnt;
      p_xp = s_if.xp_out;
      p_yp = s_if.yp_out;
   end

   // Collector of beats presented with ready
   typedef struct {
      logic [8:0]  x, y;
      logic [23:0] xp, yp;
   } beat_t;
   beat_t acc_q[$];

   always @(negedge clk) begin
      if (!rst && s_if.out_valid && s_if.out_ready)
         acc_q.push_back('{s_if.x_cnt, s_if.y_cnt,
                           s_if.xp_out, s_if.yp_out});
   end

   task automatic set_cfg(input logic [8:0] a, input logic [8:0] b,
      input logic [23:0] o1, input logic [23:0] o2,
      input logic [23:0] i1, input logic [23:0] i2,
      input logic [23:0] i3, input logic [23:0] i4);
      xl = a; yl = b; ox = o1; oy = o2;
      ixx = i1; ixy = i2; iyx = i3; iyy = i4;
   endtask

   // Called at posedge+2; start is sampled on the following edge
   task automatic pulse_start();
      start = 1'b1;
      acc_q.delete();
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   // Returns at the negedge before the last beat is accepted
   task automatic drive_frame(input bit rnd, output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk);
         if (s_if.out_valid && s_if.out_ready && m_busy &&
             m_idx == m_n() - 1) break;
         cyc++;
         if (cyc > 4000) begin
            chk("timeout", 1, 0);
            break;
         end
         @(posedge clk); #2;
         s_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   // Runs a whole frame; ends at posedge+2 of the done cycle
   task automatic run_frame(input bit rnd, output int cyc);
      pulse_start();
      drive_frame(rnd, cyc);
      @(posedge clk); #2;
      s_if.out_ready = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int cyc;
      int lit1 [6];
      lit1 = '{100, 101, 102, 110, 111, 112};
      s_if.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", s_if.out_valid, 0);
      chk("rst_xp", s_if.xp_out, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      idle(1);

      // T1: full-rate 2x3 frame
      set_cfg(1, 2, 100, 0, 10, 1, 0, 0);
      run_frame(0, cyc);
      chk("t1_rate", cyc, 5);
      chk("t1_done", done, 1);
      chk("t1_n", acc_q.size(), 6);
      for (int i = 0; i < 6 && i < acc_q.size(); i++)
         chk("t1_xp", acc_q[i].xp, lit1[i]);
      idle(1);

      // T2: same frame with random backpressure
      run_frame(1, cyc);
      chk("t2_n", acc_q.size(), 6);
      for (int i = 0; i < 6 && i < acc_q.size(); i++)
         chk("t2_xp", acc_q[i].xp, lit1[i]);
      idle(2);

      // T3: single pixel frame
      set_cfg(0, 0, 5, 7, 1, 1, 1, 1);
      run_frame(0, cyc);
      chk("t3_done", done, 1);
      chk("t3_n", acc_q.size(), 1);
      if (acc_q.size() > 0) begin
         chk("t3_yp", acc_q[0].yp, 7);
         chk("t3_x", acc_q[0].x, 0);
      end
      idle(1);

      // T4: accumulator wrap
      set_cfg(0, 1, 24'hFFFFFE, 0, 0, 3, 0, 0);
      run_frame(0, cyc);
      chk("t4_n", acc_q.size(), 2);
      if (acc_q.size() == 2) begin
         chk("t4_xp0", acc_q[0].xp, 24'hFFFFFE);
         chk("t4_xp1", acc_q[1].xp, 24'h000001);
      end
      idle(1);

      // T5: abort after three beats of a 4x4 frame
      set_cfg(3, 3, 40, 50, 4, 1, 2, 3);
      pulse_start();
      repeat (3) @(posedge clk);
      #2;
      chk("t5_beats", acc_q.size(), 3);
      abort = 1'b1;
      @(posedge clk); #2;
      abort = 1'b0;
      @(negedge clk);
      chk("t5_busy", busy, 0);
      chk("t5_valid", s_if.out_valid, 0);
      chk("t5_x", s_if.x_cnt, 0);
      idle(3);
      pulse_start();
      @(negedge clk);
      chk("t5_fresh_y", s_if.y_cnt, 0);
      chk("t5_fresh_xp", s_if.xp_out, 40);
      drive_frame(0, cyc);
      idle(2);

      // start+abort together while idle: stays idle
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #2;
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", busy, 0);

      // T6: start mid-frame is ignored
      set_cfg(2, 2, 1000, 2000, 9, 8, 7, 6);
      pulse_start();
      idle(2);
      ox = 24'h123456;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      drive_frame(1, cyc);
      @(posedge clk); #2;
      s_if.out_ready = 1'b1;
      chk("t6_n", acc_q.size(), 9);
      if (acc_q.size() > 0) chk("t6_xp0", acc_q[0].xp, 1000);
      idle(1);

      // T6: reset mid-frame
      set_cfg(3, 3, 11, 22, 1, 2, 3, 4);
      pulse_start();
      idle(3);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_x", s_if.x_cnt, 0);
      chk("t6_rst_y", s_if.y_cnt, 0);
      chk("t6_rst_xp", s_if.xp_out, 0);
      chk("t6_rst_yp", s_if.yp_out, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      idle(1);

      // Random frames; odd ones restart in the done cycle
      for (int k = 0; k < 10; k++) begin
         set_cfg(9'($urandom_range(0, 4)), 9'($urandom_range(0, 4)),
                 24'($urandom), 24'($urandom), 24'($urandom),
                 24'($urandom), 24'($urandom), 24'($urandom));
         run_frame(k[0], cyc);
         if (!k[0]) idle(1);
      end
      set_cfg(15, 15, 24'($urandom), 24'($urandom), 24'($urandom),
              24'($urandom), 24'($urandom), 24'($urandom));
      run_frame(1, cyc);
      chk("big_n", acc_q.size(), 256);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
